// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU decoder and the multiply/divide unit:
// ALU operation codes, opcode/funct encodings and the sequencer state type.
package alu_pkg;

  localparam logic [4:0] ALU_PASS = 5'h00;
  localparam logic [4:0] ALU_ADD  = 5'h01;
  localparam logic [4:0] ALU_SUB  = 5'h02;
  localparam logic [4:0] ALU_AND  = 5'h03;
  localparam logic [4:0] ALU_OR   = 5'h04;
  localparam logic [4:0] ALU_XOR  = 5'h05;
  localparam logic [4:0] ALU_NOR  = 5'h06;
  localparam logic [4:0] ALU_SLL  = 5'h07;
  localparam logic [4:0] ALU_SRL  = 5'h08;
  localparam logic [4:0] ALU_SLT  = 5'h09;
  localparam logic [4:0] ALU_MD   = 5'h0A;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

  // Every funct that touches HI/LO and therefore must wait for the sequencer.
  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
           (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide sequencer: magnitude shift-add / restoring
// shift-subtract over DATA_W cycles, followed by one sign-correction cycle.
module md_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_div,
  input  logic              start_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  md_state_t           state;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   raw_a;
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic                neg_lo;
  logic                neg_hi;
  logic                div_zero;

  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] prod_fix;

  assign abs_a = (start_signed && a[DATA_W-1]) ? -a : a;
  assign abs_b = (start_signed && b[DATA_W-1]) ? -b : b;

  // acc = {partial product, remaining multiplier bits}; carry shifts back in.
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[DATA_W-1:1]};

  // acc = {partial remainder, dividend bits becoming quotient bits}.
  assign div_shift = acc[2*DATA_W-1:DATA_W-1];
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_next  = div_diff[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                                      : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

  assign busy = (state != IDLE);
  assign done = (state == FIX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      opb      <= '0;
      raw_a    <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= {{DATA_W{1'b0}}, (start_div ? abs_a : abs_b)};
            opb      <= start_div ? abs_b : abs_a;
            raw_a    <= a;
            cnt      <= CNT_W'(DATA_W);
            is_div   <= start_div;
            neg_lo   <= start_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_hi   <= start_signed && (start_div ? a[DATA_W-1]
                                                   : (a[DATA_W-1] ^ b[DATA_W-1]));
            div_zero <= (b == '0);
            state    <= start_div ? DIV : MUL;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sign correction; divide by zero bypasses it and reports the raw dividend.
  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    hi_res   = '0;
    lo_res   = '0;
    if (!is_div) begin
      hi_res = prod_fix[2*DATA_W-1:DATA_W];
      lo_res = prod_fix[DATA_W-1:0];
    end else if (div_zero) begin
      hi_res = raw_a;
      lo_res = '1;
    end else begin
      hi_res = neg_hi ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
      lo_res = neg_lo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU decoder with HI/LO registers, multiply/divide sequencer and
// the stall that holds dependent md instructions while the unit is busy.
module alu_md_control
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit MD_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [4:0]        alu_ctrl,
  output logic              sign,
  output logic [DATA_W-1:0] md_result,
  output logic              stall,
  output logic              busy
);

  logic              is_r;
  logic              md_op;
  logic              accept;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  assign is_r   = (opcode == OP_RTYPE);
  assign md_op  = MD_EN && valid_i && is_r && is_md_funct(funct);
  assign stall  = md_op && busy;
  assign accept = md_op && !busy;

  always_comb begin
    alu_ctrl = ALU_PASS;
    sign     = 1'b1;
    if (is_r) begin
      case (funct)
        F_ADD:  alu_ctrl = ALU_ADD;
        F_ADDU: begin alu_ctrl = ALU_ADD; sign = 1'b0; end
        F_SUB:  alu_ctrl = ALU_SUB;
        F_SUBU: begin alu_ctrl = ALU_SUB; sign = 1'b0; end
        F_AND:  alu_ctrl = ALU_AND;
        F_OR:   alu_ctrl = ALU_OR;
        F_XOR:  alu_ctrl = ALU_XOR;
        F_NOR:  alu_ctrl = ALU_NOR;
        F_SLL:  begin alu_ctrl = ALU_SLL; sign = 1'b0; end
        F_SRL:  begin alu_ctrl = ALU_SRL; sign = 1'b0; end
        F_SRA:  alu_ctrl = ALU_SRL;
        F_SLT:  alu_ctrl = ALU_SLT;
        F_SLTU: begin alu_ctrl = ALU_SLT; sign = 1'b0; end
        F_MFHI, F_MFLO: begin
          if (MD_EN) alu_ctrl = ALU_MD;
        end
        F_MULTU, F_DIVU: begin
          if (MD_EN) sign = 1'b0;
        end
        default: ;
      endcase
    end else begin
      case (opcode)
        OP_ADDI:        alu_ctrl = ALU_ADD;
        OP_ADDIU:       begin alu_ctrl = ALU_ADD; sign = 1'b0; end
        OP_SLTI:        alu_ctrl = ALU_SLT;
        OP_SLTIU:       begin alu_ctrl = ALU_SLT; sign = 1'b0; end
        OP_ANDI:        alu_ctrl = ALU_AND;
        OP_ORI:         alu_ctrl = ALU_OR;
        OP_XORI:        alu_ctrl = ALU_XOR;
        OP_LW, OP_SW:   alu_ctrl = ALU_ADD;
        OP_BEQ, OP_BNE: alu_ctrl = ALU_SUB;
        default: ;
      endcase
    end
  end

  always_comb begin
    md_result = '0;
    if (MD_EN && is_r) begin
      if (funct == F_MFHI)      md_result = hi_q;
      else if (funct == F_MFLO) md_result = lo_q;
    end
  end

  generate
    if (MD_EN) begin : g_md
      logic              iter_done;
      logic [DATA_W-1:0] iter_hi;
      logic [DATA_W-1:0] iter_lo;
      logic              start_md;
      logic              start_div;

      assign start_md  = accept && ((funct == F_MULT) || (funct == F_MULTU) ||
                                    (funct == F_DIV)  || (funct == F_DIVU));
      assign start_div = (funct == F_DIV) || (funct == F_DIVU);

      md_iter #(.DATA_W(DATA_W)) u_iter (
        .clk          (clk),
        .reset        (reset),
        .start        (start_md),
        .start_div    (start_div),
        .start_signed ((funct == F_MULT) || (funct == F_DIV)),
        .a            (rs_val),
        .b            (rt_val),
        .busy         (busy),
        .done         (iter_done),
        .hi_res       (iter_hi),
        .lo_res       (iter_lo)
      );

      // mthi/mtlo can never coincide with FIX because they stall while busy.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hi_q <= '0;
          lo_q <= '0;
        end else if (iter_done) begin
          hi_q <= iter_hi;
          lo_q <= iter_lo;
        end else if (accept && funct == F_MTHI) begin
          hi_q <= rs_val;
        end else if (accept && funct == F_MTLO) begin
          lo_q <= rs_val;
        end
      end
    end else begin : g_no_md
      assign busy = 1'b0;
      assign hi_q = '0;
      assign lo_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_md_control.sv
// Directed bench for alu_md_control: legacy decode, mult/div results and
// latency, stall behaviour, mthi/mtlo, reset mid-operation, 16-bit and no-md builds.
module tb_alu_md_control;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic [4:0]  alu_ctrl, ctrl16, ctrl_n;
  logic        sign, sign16, sign_n;
  logic [31:0] md_result, res_n;
  logic [15:0] res16;
  logic        stall, stall16, stall_n;
  logic        busy, busy16, busy_n;

  int checks = 0;
  int errors = 0;
  int nomd_activity = 0;

  always #5 clk = ~clk;

  alu_md_control #(.DATA_W(32), .MD_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .opcode(opcode), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .alu_ctrl(alu_ctrl), .sign(sign),
    .md_result(md_result), .stall(stall), .busy(busy)
  );

  alu_md_control #(.DATA_W(16), .MD_EN(1'b1)) u_dut16 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .opcode(opcode), .funct(funct),
    .rs_val(rs_val[15:0]), .rt_val(rt_val[15:0]), .alu_ctrl(ctrl16), .sign(sign16),
    .md_result(res16), .stall(stall16), .busy(busy16)
  );

  alu_md_control #(.DATA_W(32), .MD_EN(1'b0)) u_nomd (
    .clk(clk), .reset(reset), .valid_i(valid_i), .opcode(opcode), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .alu_ctrl(ctrl_n), .sign(sign_n),
    .md_result(res_n), .stall(stall_n), .busy(busy_n)
  );

  always @(negedge clk) if (stall_n !== 1'b0 || busy_n !== 1'b0) nomd_activity++;

  // {opcode, funct, expected alu_ctrl, expected sign}
  logic [17:0] dec_tbl [0:36] = '{
    {6'h00, 6'h20, 5'h01, 1'b1}, {6'h00, 6'h21, 5'h01, 1'b0}, {6'h00, 6'h22, 5'h02, 1'b1},
    {6'h00, 6'h23, 5'h02, 1'b0}, {6'h00, 6'h24, 5'h03, 1'b1}, {6'h00, 6'h25, 5'h04, 1'b1},
    {6'h00, 6'h26, 5'h05, 1'b1}, {6'h00, 6'h27, 5'h06, 1'b1}, {6'h00, 6'h00, 5'h07, 1'b0},
    {6'h00, 6'h02, 5'h08, 1'b0}, {6'h00, 6'h03, 5'h08, 1'b1}, {6'h00, 6'h2A, 5'h09, 1'b1},
    {6'h00, 6'h2B, 5'h09, 1'b0}, {6'h00, 6'h08, 5'h00, 1'b1}, {6'h00, 6'h10, 5'h0A, 1'b1},
    {6'h00, 6'h12, 5'h0A, 1'b1}, {6'h00, 6'h11, 5'h00, 1'b1}, {6'h00, 6'h13, 5'h00, 1'b1},
    {6'h00, 6'h18, 5'h00, 1'b1}, {6'h00, 6'h19, 5'h00, 1'b0}, {6'h00, 6'h1A, 5'h00, 1'b1},
    {6'h00, 6'h1B, 5'h00, 1'b0}, {6'h00, 6'h3F, 5'h00, 1'b1},
    {6'h08, 6'h1B, 5'h01, 1'b1}, {6'h09, 6'h1B, 5'h01, 1'b0}, {6'h0A, 6'h1B, 5'h09, 1'b1},
    {6'h0B, 6'h1B, 5'h09, 1'b0}, {6'h0C, 6'h1B, 5'h03, 1'b1}, {6'h0D, 6'h1B, 5'h04, 1'b1},
    {6'h0E, 6'h1B, 5'h05, 1'b1}, {6'h0F, 6'h1B, 5'h00, 1'b1}, {6'h23, 6'h1B, 5'h01, 1'b1},
    {6'h2B, 6'h1B, 5'h01, 1'b1}, {6'h04, 6'h1B, 5'h02, 1'b1}, {6'h05, 6'h1B, 5'h02, 1'b1},
    {6'h02, 6'h1B, 5'h00, 1'b1}, {6'h3F, 6'h1B, 5'h00, 1'b1}
  };

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] f,
                               input logic [31:0] a, input logic [31:0] b);
    valid_i = v;
    opcode  = op;
    funct   = f;
    rs_val  = a;
    rt_val  = b;
  endtask

  // Issues one md op, counts busy cycles (bounded) and reads HI/LO back.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, f, a, b);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    applyStimulus(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1 hi = md_result;
    applyStimulus(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1 lo = md_result;
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    #12;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy_stall: got busy=%b stall=%b, want 0/0", busy, stall);
    end
    applyStimulus(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    checks++;
    if (md_result !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mfhi: got md_result=%h stall=%b, want 0/0", md_result, stall);
    end
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_legacy_decode();
    logic [17:0] e;
    for (int i = 0; i < 37; i++) begin
      e = dec_tbl[i];
      applyStimulus(1'b0, e[17:12], e[11:6], 32'h0, 32'h0);
      #1;
      checks++;
      if ({alu_ctrl, sign} !== e[5:0]) begin
        errors++;
        $display("[TB] FAIL decode op=%h fn=%h: got ctrl=%h sign=%b, want ctrl=%h sign=%b",
                 e[17:12], e[11:6], alu_ctrl, sign, e[5:1], e[0]);
      end
    end
    applyStimulus(1'b0, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    checks++;
    if (ctrl_n !== 5'h00 || sign_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nomd_mfhi_decode: got ctrl=%h sign=%b, want 00/1", ctrl_n, sign_n);
    end
    applyStimulus(1'b0, 6'h00, 6'h19, 32'h0, 32'h0);
    #1;
    checks++;
    if (ctrl_n !== 5'h00 || sign_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nomd_multu_decode: got ctrl=%h sign=%b, want 00/1", ctrl_n, sign_n);
    end
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic test_mult();
    int cyc;
    logic [31:0] hi, lo;
    run_md(6'h18, 32'hFFFFFFFD, 32'h7, cyc, hi, lo);
    checks++;
    if (cyc !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++;
      $display("[TB] FAIL mult_neg3x7: got cyc=%0d hi=%h lo=%h, want 33 ffffffff ffffffeb",
               cyc, hi, lo);
    end
    run_md(6'h19, 32'hFFFFFFFF, 32'h2, cyc, hi, lo);
    checks++;
    if (cyc !== 33 || hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("[TB] FAIL multu_max_x2: got cyc=%0d hi=%h lo=%h, want 33 00000001 fffffffe",
               cyc, hi, lo);
    end
  endtask

  task automatic test_div();
    int cyc;
    logic [31:0] hi, lo;
    run_md(6'h1A, 32'hFFFFFFF9, 32'h2, cyc, hi, lo);
    checks++;
    if (cyc !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("[TB] FAIL div_neg7_2: got cyc=%0d hi=%h lo=%h, want 33 ffffffff fffffffd",
               cyc, hi, lo);
    end
    run_md(6'h1B, 32'h7, 32'h0, cyc, hi, lo);
    checks++;
    if (cyc !== 33 || hi !== 32'h7 || lo !== 32'hFFFFFFFF) begin
      errors++;
      $display("[TB] FAIL divu_by_zero: got cyc=%0d hi=%h lo=%h, want 33 00000007 ffffffff",
               cyc, hi, lo);
    end
    run_md(6'h1A, 32'h80000000, 32'hFFFFFFFF, cyc, hi, lo);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      errors++;
      $display("[TB] FAIL div_min_neg1: got hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
    run_md(6'h1A, 32'hFFFFFFF9, 32'h0, cyc, hi, lo);
    checks++;
    if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin
      errors++;
      $display("[TB] FAIL div_signed_by_zero: got hi=%h lo=%h, want fffffff9 ffffffff", hi, lo);
    end
  endtask

  task automatic test_stall();
    int cnt;
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h19, 32'h3, 32'h5);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    cnt = 0;
    while (stall === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (cnt !== 32) begin
      errors++;
      $display("[TB] FAIL mflo_stall_len: got %0d cycles, want 32", cnt);
    end
    checks++;
    if (md_result !== 32'd15 || alu_ctrl !== 5'h0A || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mflo_after_stall: got res=%h ctrl=%h busy=%b, want 0000000f 0a 0",
               md_result, alu_ctrl, busy);
    end
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int cnt, cyc;
    logic [31:0] hi, lo;
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h18, 32'h2, 32'h3);
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h18, 32'h4, 32'h5);
    #1;
    cnt = 0;
    while (stall === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (cnt !== 33) begin
      errors++;
      $display("[TB] FAIL second_mult_stall: got %0d cycles, want 33", cnt);
    end
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    applyStimulus(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1 hi = md_result;
    applyStimulus(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1 lo = md_result;
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    checks++;
    if (cyc !== 33 || hi !== 32'h0 || lo !== 32'd20) begin
      errors++;
      $display("[TB] FAIL second_mult_result: got cyc=%0d hi=%h lo=%h, want 33 0 00000014",
               cyc, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h13, 32'h1234, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtlo_stall: got %b, want 0", stall);
    end
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    checks++;
    if (md_result !== 32'h1234 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtlo_mflo: got res=%h stall=%b, want 00001234 0", md_result, stall);
    end
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h11, 32'hCAFEF00D, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    checks++;
    if (md_result !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL mthi_mfhi: got %h, want cafef00d", md_result);
    end
    checks++;
    if (res_n !== 32'h0) begin
      errors++;
      $display("[TB] FAIL nomd_mfhi_result: got %h, want 0", res_n);
    end
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic test_reset_midop();
    int cyc;
    logic [31:0] hi, lo;
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h11, 32'hAAAA5555, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h13, 32'h12345678, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h1A, 32'd100, 32'd7);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_busy: got %b, want 0", busy);
    end
    applyStimulus(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    checks++;
    if (md_result !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_hi: got res=%h stall=%b, want 0 0", md_result, stall);
    end
    applyStimulus(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    checks++;
    if (md_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_lo: got %h, want 0", md_result);
    end
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    checks++;
    if (md_result !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL discarded_result: got lo=%h busy=%b, want 0 0", md_result, busy);
    end
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    run_md(6'h18, 32'd6, 32'd7, cyc, hi, lo);
    checks++;
    if (cyc !== 33 || hi !== 32'h0 || lo !== 32'd42) begin
      errors++;
      $display("[TB] FAIL mult_after_reset: got cyc=%0d hi=%h lo=%h, want 33 0 0000002a",
               cyc, hi, lo);
    end
  endtask

  task automatic test_width16();
    int cyc;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 6'h00, 6'h18, 32'h0000FFFD, 32'h7);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    cyc = 0;
    while (busy16 === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 17) begin
      errors++;
      $display("[TB] FAIL w16_busy_len: got %0d cycles, want 17", cyc);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    applyStimulus(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    checks++;
    if (res16 !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL w16_hi: got %h, want ffff", res16);
    end
    applyStimulus(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    checks++;
    if (res16 !== 16'hFFEB) begin
      errors++;
      $display("[TB] FAIL w16_lo: got %h, want ffeb", res16);
    end
    applyStimulus(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic test_nomd();
    @(negedge clk);
    checks++;
    if (nomd_activity !== 0) begin
      errors++;
      $display("[TB] FAIL nomd_stall_busy: got %0d active cycles, want 0", nomd_activity);
    end
  endtask

  initial begin
    test_reset();
    test_legacy_decode();
    test_mult();
    test_div();
    test_stall();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_midop();
    test_width16();
    test_nomd();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
